// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator for the video display path. It walks a pixel
// position (h, v) across a frame of H_TOTAL x V_TOTAL clocks and decodes
// sync, blanking, display-enable and coordinate outputs from it. A small
// start/stop FSM ensures a frame in progress always runs to its last pixel
// before the generator goes idle when enable is dropped.
//
// Ports:
//   fpga_CLK_AUX  in   pixel clock
//   n_rst         in   asynchronous active-low reset
//   enable        in   video-on request, synchronous to fpga_CLK_AUX
//   hsync         out  horizontal sync, active level HS_POL
//   vsync         out  vertical sync, active level VS_POL
//   de            out  display enable, 1 inside the active area
//   blank         out  ~de while running, 1 when idle
//   x_pos         out  pixel column (raw h counter)
//   y_pos         out  pixel line (raw v counter)
//   line_start    out  one-cycle pulse at h=0 of every line
//   frame_start   out  one-cycle pulse at h=0, v=0
//   running       out  1 while a frame is being generated
// All outputs are registered and describe the same (h, v) position.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int   H_DISP  = 800,
  parameter int   H_FP    = 40,
  parameter int   H_SYNC  = 48,
  parameter int   H_BP    = 40,
  parameter int   V_DISP  = 480,
  parameter int   V_FP    = 13,
  parameter int   V_SYNC  = 3,
  parameter int   V_BP    = 29,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  localparam int  H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP,
  localparam int  HW      = $clog2(H_TOTAL),
  localparam int  VW      = $clog2(V_TOTAL)
) (
  input  logic          fpga_CLK_AUX,
  input  logic          n_rst,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          blank,
  output logic [HW-1:0] x_pos,
  output logic [VW-1:0] y_pos,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  // Sync windows as half-open ranges [START, END)
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [HW-1:0] H_ONE = HW'(32'd1);
  localparam logic [VW-1:0] V_ONE = VW'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [HW-1:0] h_r, h_nxt_s, h_adv_s;
  logic [VW-1:0] v_r, v_nxt_s, v_adv_s;
  logic          h_last_s, v_last_s;

  logic [31:0]   h_i_s, v_i_s;
  logic          act_s;
  logic          hsync_nxt_s, vsync_nxt_s, de_nxt_s;
  logic          line_start_nxt_s, frame_start_nxt_s;

  logic          hsync_r, vsync_r, de_r, blank_r;
  logic          line_start_r, frame_start_r, running_r;
  logic [HW-1:0] x_pos_r;
  logic [VW-1:0] y_pos_r;

  // Next-state and next-position logic of the start/stop FSM
  always_comb begin
    h_last_s    = (32'(h_r) == 32'(H_TOTAL - 1));
    v_last_s    = (32'(v_r) == 32'(V_TOTAL - 1));
    h_adv_s     = h_last_s ? {HW{1'b0}} : (h_r + H_ONE);
    if (h_last_s) begin
      v_adv_s = v_last_s ? {VW{1'b0}} : (v_r + V_ONE);
    end else begin
      v_adv_s = v_r;
    end
    state_nxt_s = ST_IDLE;
    h_nxt_s     = {HW{1'b0}};
    v_nxt_s     = {VW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        // Leaving idle always starts at (0,0), so the first running
        // cycle carries frame_start.
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        h_nxt_s = h_adv_s;
        v_nxt_s = v_adv_s;
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        // Only the last pixel of a frame may end the run; elsewhere the
        // counters keep going so no line or frame is ever truncated.
        h_nxt_s = h_adv_s;
        v_nxt_s = v_adv_s;
        if (enable) begin
          state_nxt_s = ST_RUN;
        end else if (h_last_s && v_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOPPING;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Decode the outputs for the position the counters move to next, so the
  // registered outputs line up with the registered counters
  always_comb begin
    act_s = (state_nxt_s != ST_IDLE);
    h_i_s = 32'(h_nxt_s);
    v_i_s = 32'(v_nxt_s);
    de_nxt_s = act_s && (h_i_s < 32'(H_DISP)) && (v_i_s < 32'(V_DISP));
    if (act_s && (h_i_s >= 32'(HS_START)) && (h_i_s < 32'(HS_END))) begin
      hsync_nxt_s = HS_POL;
    end else begin
      hsync_nxt_s = ~HS_POL;
    end
    if (act_s && (v_i_s >= 32'(VS_START)) && (v_i_s < 32'(VS_END))) begin
      vsync_nxt_s = VS_POL;
    end else begin
      vsync_nxt_s = ~VS_POL;
    end
    line_start_nxt_s  = act_s && (h_nxt_s == {HW{1'b0}});
    frame_start_nxt_s = line_start_nxt_s && (v_nxt_s == {VW{1'b0}});
  end

  // State, counter and output registers; reset forces idle values at once
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      h_r           <= {HW{1'b0}};
      v_r           <= {VW{1'b0}};
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      de_r          <= 1'b0;
      blank_r       <= 1'b1;
      x_pos_r       <= {HW{1'b0}};
      y_pos_r       <= {VW{1'b0}};
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      running_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      h_r           <= h_nxt_s;
      v_r           <= v_nxt_s;
      hsync_r       <= hsync_nxt_s;
      vsync_r       <= vsync_nxt_s;
      de_r          <= de_nxt_s;
      blank_r       <= ~de_nxt_s;
      x_pos_r       <= h_nxt_s;
      y_pos_r       <= v_nxt_s;
      line_start_r  <= line_start_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      running_r     <= act_s;
    end
  end

  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign de          = de_r;
  assign blank       = blank_r;
  assign x_pos       = x_pos_r;
  assign y_pos       = y_pos_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign running     = running_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Small-raster bench (H 8/2/2/2 = 14, V 4/1/1/1 = 7). The driver issues one
// enable value per clock, advances a frame-index reference model and queues
// the expected outputs; an independent monitor pops and compares each cycle
// and also checks frame period and active-pixel count per frame.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int H_T   = 14;
  localparam int V_T   = 7;
  localparam int FRAME = H_T * V_T;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       blank;
    logic [3:0] x;
    logic [2:0] y;
    logic       ls;
    logic       fs;
    logic       run;
  } out_t;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic       hsync, vsync, de, blank;
  logic [3:0] x_pos;
  logic [2:0] y_pos;
  logic       line_start, frame_start, running;

  int n_checks = 0;
  int n_pass   = 0;

  out_t exp_q[$];

  // Reference model: position expressed as an index into the frame
  bit m_active  = 1'b0;
  int m_p       = 0;
  bit m_last_en = 1'b0;

  video_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .fpga_CLK_AUX(clk),
    .n_rst       (n_rst),
    .enable      (enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .blank       (blank),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    int h, v;
    h = m_p % H_T;
    v = m_p / H_T;
    e.de    = m_active && (h < 8) && (v < 4);
    e.hs    = !(m_active && (h >= 10) && (h < 12));
    e.vs    = !(m_active && (v == 5));
    e.blank = !e.de;
    e.x     = 4'(h);
    e.y     = 3'(v);
    e.ls    = m_active && (h == 0);
    e.fs    = m_active && (m_p == 0);
    e.run   = m_active;
    return e;
  endfunction

  // One clock of stimulus: drive enable, advance the model, queue expectation
  task automatic step(input logic en);
    @(negedge clk);
    enable = en;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_p      = 0;
      end
    end else if ((m_p == FRAME - 1) && !m_last_en && !en) begin
      m_active = 1'b0;
      m_p      = 0;
    end else begin
      m_p = (m_p + 1) % FRAME;
    end
    m_last_en = en;
    exp_q.push_back(model_out());
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hsync"}, 16'(hsync), 16'd1);
    check({tag, "_vsync"}, 16'(vsync), 16'd1);
    check({tag, "_de"}, 16'(de), 16'd0);
    check({tag, "_blank"}, 16'(blank), 16'd1);
    check({tag, "_xy"}, 16'({x_pos, y_pos}), 16'd0);
    check({tag, "_pulses"}, 16'({line_start, frame_start}), 16'd0);
    check({tag, "_running"}, 16'(running), 16'd0);
  endtask

  // Mid-cycle asynchronous reset: idle values must appear without a clock
  task automatic async_reset();
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_idle("async_rst");
    exp_q.delete();
    m_active  = 1'b0;
    m_p       = 0;
    m_last_en = 1'b0;
    enable    = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  // Monitor: compare every cycle's outputs and track frame-level properties
  bit frm_valid = 1'b0;
  bit prev_run  = 1'b0;
  int since_fs  = 0;
  int de_cnt    = 0;
  always @(posedge clk) begin
    out_t act, exp;
    #1;
    act = {hsync, vsync, de, blank, x_pos, y_pos, line_start, frame_start, running};
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("scoreboard", 16'(act), 16'(exp));
    end
    if (!n_rst) begin
      frm_valid = 1'b0;
    end else begin
      if (frame_start) begin
        if (frm_valid) begin
          check("frame_period", 16'(since_fs), 16'(FRAME));
          check("de_per_frame", 16'(de_cnt), 16'd32);
        end
        frm_valid = 1'b1;
        since_fs  = 0;
        de_cnt    = 0;
      end else if (prev_run && !running && frm_valid) begin
        check("stop_frame_len", 16'(since_fs), 16'(FRAME));
        check("stop_de_count", 16'(de_cnt), 16'd32);
        frm_valid = 1'b0;
      end
      since_fs++;
      if (de) de_cnt++;
    end
    prev_run = running;
  end

  initial begin
    logic en_r;
    n_rst  = 1'b0;
    enable = 1'b0;
    #12 check_idle("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    repeat (3) step(1'b0);

    // Start and two complete frames
    repeat (2 * FRAME) step(1'b1);

    // Drop enable when outputs show (3,1); frame must finish then idle
    for (int i = 0; i < 200 && !(m_active && m_p == H_T + 3); i++) step(1'b1);
    for (int i = 0; i < 200 && m_active; i++) step(1'b0);
    repeat (4) step(1'b0);

    // Stop mid-frame, then re-raise enable on line 5 while stopping
    for (int i = 0; i < 200 && !(m_active && m_p == 20); i++) step(1'b1);
    for (int i = 0; i < 200 && (m_p / H_T) != 5; i++) step(1'b0);
    repeat (3 * FRAME) step(1'b1);

    // Randomised enable with long runs, including one mid-frame reset
    en_r = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      if (i == 800) begin
        for (int j = 0; j < 200 && !(m_active && m_p > 30); j++) step(1'b1);
        async_reset();
      end
      step(en_r);
    end

    @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
